alu_mc_core: RTL
================

ALU_MC_CORE -- requirements
Module: alu_mc_core

Interface
REQ-001 Parameter N, default 32: operand/result width in bits, legal range 8..64.
REQ-002 Parameter OPW, default 4: opcode width in bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  OPW  operation select.
REQ-008 a, b  input  N each  operands A and B.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  N  operation result.
REQ-012 flags  output  4  {N,Z,C,V}.
REQ-013 err  output  1  illegal opcode, or divide by zero.

Function
REQ-014 Opcodes:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT (~a).
- 0110 ASL, 0111 ASR, 1000 LSL, 1001 LSR, 1010 DIV (unsigned a/b).
- Codes 1011..1111 illegal.
REQ-015 Shift amount = b[$clog2(N)-1:0]; ASL identical to LSL; ASR sign-fills from a[N-1].
REQ-016 Handshake: operation accepted when in_valid && in_ready; out result consumed when out_valid && out_ready.
REQ-017 in_ready = (state==IDLE) && (!out_valid || out_ready); accept and consume in the same cycle allowed.
REQ-018 Non-DIV ops: result/flags/err registered, out_valid asserted the cycle after accept (latency 1).
REQ-019 DIV: FSM IDLE -> BUSY on accept; BUSY lasts exactly N cycles (one restoring step per cycle); BUSY -> IDLE loading output register, out_valid in cycle N+1 after accept.
REQ-020 in_ready = 0 throughout BUSY.
REQ-021 result, flags, err held stable while out_valid && !out_ready.
REQ-022 Flag N = result[N-1]; Z = (result==0).
REQ-023 ADD: C = carry out; V = signed overflow.
REQ-024 SUB: C = 1 when a >= b unsigned (no borrow); V = signed overflow.
REQ-025 All other ops: C = 0, V = 0.
REQ-026 DIV with b==0: skip BUSY, latency 1, result all ones, err = 1.
REQ-027 Illegal opcode: latency 1, result 0, flags computed on 0 (Z=1), err = 1.
REQ-028 in_valid while in_ready=0: ignored, not queued.

Reset
REQ-029 rst_n low: state=IDLE, out_valid=0, result=0, flags=0, err=0, divider registers cleared, immediately (asynchronously).
REQ-030 Reset during BUSY aborts division; no result produced after release.
REQ-031 in_ready = 1 the first cycle after rst_n deasserts.

Configuration
REQ-032 Macro ALU_MC_DIV_EN defined: DIV implemented per REQ-019/026.
REQ-033 Macro undefined: no divider logic; 1010 treated as illegal per REQ-027; FSM never enters BUSY.

Structure
REQ-034 Package alu_mc_pkg: op enum (ALU_ADD..ALU_DIV), flag bit indices, FSM state enum {IDLE, BUSY}.
REQ-035 Sub-module alu_mc_divider: iterative N-step unsigned restoring divider, start/done interface, instantiated only under ALU_MC_DIV_EN.

Verification (N=32)
REQ-036 ADD a=0x7FFFFFFF b=1 -> next cycle result 0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-037 SUB a=5 b=5 -> result 0, Z=1 C=1 V=0; SUB a=0 b=1 -> 0xFFFFFFFF, N=1 C=0.
REQ-038 ASR a=0x80000000 b=0x21 (amount 1) -> 0xC0000000; LSR same -> 0x40000000.
REQ-039 DIV a=100 b=7 -> in_ready low 32 cycles, out_valid at cycle 33, result 14, err 0; b=0 -> cycle 1, 0xFFFFFFFF, err 1.
REQ-040 Hold out_ready=0 for 5 cycles after a result -> result stable, in_ready=0; op 1101 -> result 0, Z=1, err 1.
REQ-041 Assert rst_n=0 at cycle 10 of a DIV -> out_valid stays 0, in_ready=1 first cycle after release.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, flag bit positions
// and the controller state encoding.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOT = 4'b0101,
    ALU_ASL = 4'b0110,
    ALU_ASR = 4'b0111,
    ALU_LSL = 4'b1000,
    ALU_LSR = 4'b1001,
    ALU_DIV = 4'b1010
  } alu_op_e;

  // Positions inside the 4-bit {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mc_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, N steps.
// done is asserted during the final step and quotient then shows the
// finished quotient, so the parent can capture it on that same edge.
module alu_mc_divider
  import alu_mc_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0] rem;
  logic [N-1:0] quo;
  logic [N-1:0] dvs;
  logic [CW-1:0] count;
  logic         busy;

  logic [N:0]   shifted;
  logic [N:0]   trial;
  logic [N-1:0] rem_next;
  logic [N-1:0] quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted  = {rem, quo[N-1]};
    trial    = shifted - {1'b0, dvs};
    rem_next = shifted[N-1:0];
    quo_next = {quo[N-2:0], 1'b0};
    if (!trial[N]) begin
      rem_next = trial[N-1:0];
      quo_next = {quo[N-2:0], 1'b1};
    end
  end

  assign done     = busy && (count == CW'(1));
  assign quotient = quo_next;

  // Operand capture on start, then N iterations counted down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= CW'(N);
      busy  <= 1'b1;
    end else if (busy) begin
      rem   <= rem_next;
      quo   <= quo_next;
      count <= count - CW'(1);
      if (count == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc_core.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a registered result one cycle after accept.
// Build option: define ALU_MC_DIV_EN to include the iterative unsigned
// divider (opcode 1010); without it that opcode is reported as illegal.
module alu_mc_core
  import alu_mc_pkg::*;
#(
  parameter int N   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic [3:0]     flags,
  output logic           err
);

  localparam int SHW = $clog2(N);

  alu_state_e   state;
  logic         accept;
  logic [SHW-1:0] shamt;
  logic [N:0]   sum_ext;
  logic [N-1:0] diff;

  logic [N-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic         alu_err;
  logic [3:0]   alu_flags;
  logic         div_start;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff     = a - b;

`ifdef ALU_MC_DIV_EN
  logic         div_done;
  logic [N-1:0] div_q;

  // A zero divisor is answered immediately and never reaches the divider
  assign div_start = accept && (op == OPW'(ALU_DIV)) && (b != '0);

  alu_mc_divider #(.N(N)) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_q)
  );
`else
  assign div_start = 1'b0;
`endif

  // Single-cycle datapath: result, carry/overflow and error for the current op
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OPW'(ALU_ADD): begin
        alu_res = sum_ext[N-1:0];
        alu_c   = sum_ext[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OPW'(ALU_SUB): begin
        alu_res = diff;
        alu_c   = (a >= b);
        alu_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OPW'(ALU_AND): alu_res = a & b;
      OPW'(ALU_OR):  alu_res = a | b;
      OPW'(ALU_XOR): alu_res = a ^ b;
      OPW'(ALU_NOT): alu_res = ~a;
      OPW'(ALU_ASL): alu_res = a << shamt;
      OPW'(ALU_ASR): alu_res = $signed(a) >>> shamt;
      OPW'(ALU_LSL): alu_res = a << shamt;
      OPW'(ALU_LSR): alu_res = a >> shamt;
`ifdef ALU_MC_DIV_EN
      OPW'(ALU_DIV): begin
        if (b == '0) begin
          alu_res = '1;
          alu_err = 1'b1;
        end
      end
`endif
      default: alu_err = 1'b1;
    endcase

    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_res[N-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // Controller: accepts ops, tracks the divide, owns the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            state <= BUSY;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            flags     <= alu_flags;
            err       <= alu_err;
          end
        end
        BUSY: begin
`ifdef ALU_MC_DIV_EN
          if (div_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            result    <= div_q;
            flags     <= {div_q[N-1], (div_q == '0), 2'b00};
            err       <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
